// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   Owns the PC, issues one instruction-memory request at a time, applies
//   redirects from EX and stalls from the hazard unit. It presents the fetched
//   word with its PC to the IF/ID register.
//
// Ports
//   CLK, RST                        clock (rising edge), async active-low reset
//   STALLF                          hold the currently presented instruction
//   PCSRCE, PCTARGETE               redirect request and target from EX
//   IMEM_REQ/ADDR/GNT               request side of the memory handshake
//   IMEM_RVALID/RDATA               response side (one response per grant, in order)
//   RD, PCF, PCPLUS4F, FVALID       fetched instruction, its PC, PC+4, valid flag
//   FBUSY                           inverse of FVALID; the hazard unit bubbles ID on it
//   dbg_state                       current FSM state, for observation only
//
// Handshake: a request transfers on a cycle where IMEM_REQ and IMEM_GNT are
// both high. Exactly one IMEM_RVALID pulse follows each transfer. No second
// request is issued until that pulse has been seen, so at most one request is
// outstanding at any time.
module fetch_unit #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALLF,
    input  logic             PCSRCE,
    input  logic [WIDTH-1:0] PCTARGETE,
    output logic             IMEM_REQ,
    output logic [WIDTH-1:0] IMEM_ADDR,
    input  logic             IMEM_GNT,
    input  logic             IMEM_RVALID,
    input  logic [WIDTH-1:0] IMEM_RDATA,
    output logic [WIDTH-1:0] RD,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPLUS4F,
    output logic             FVALID,
    output logic             FBUSY,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] ibuf, ibuf_nxt;
    logic [WIDTH-1:0] pc_inc;
    logic             req_int;

    assign pc_inc = pc + WIDTH'(4);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            ibuf  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ibuf  <= ibuf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ibuf_nxt  = ibuf;
        req_int   = 1'b0;
        IMEM_ADDR = pc;
        unique case (state)
            S_REQ: begin
                req_int = 1'b1;
                if (PCSRCE) begin
                    // A granted request to the old PC is now stale: drain it.
                    pc_nxt    = PCTARGETE;
                    state_nxt = IMEM_GNT ? S_DRAIN : S_REQ;
                end else if (IMEM_GNT) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSRCE) begin
                    pc_nxt    = PCTARGETE;
                    // A response arriving with the redirect is dropped here.
                    state_nxt = IMEM_RVALID ? S_REQ : S_DRAIN;
                end else if (IMEM_RVALID) begin
                    ibuf_nxt  = IMEM_RDATA;
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (PCSRCE) begin
                    pc_nxt    = PCTARGETE;
                    state_nxt = S_REQ;
                end else if (!STALLF) begin
                    // Advance: request the next word in the same cycle the
                    // current one is consumed.
                    req_int   = 1'b1;
                    IMEM_ADDR = pc_inc;
                    pc_nxt    = pc_inc;
                    state_nxt = IMEM_GNT ? S_WAIT : S_REQ;
                end
            end
            S_DRAIN: begin
                if (PCSRCE) begin
                    pc_nxt = PCTARGETE;
                end
                if (IMEM_RVALID) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    // Reset is asynchronous, so the request is also masked directly by RST.
    assign IMEM_REQ  = req_int & RST;
    assign RD        = ibuf;
    assign PCF       = pc;
    assign PCPLUS4F  = pc_inc;
    assign FVALID    = (state == S_VALID);
    assign FBUSY     = ~FVALID;
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned W        = 32;
    localparam logic [W-1:0] RST_PC  = 32'h0000_0100;

    logic         clk;
    logic         rst_n;
    logic         stallf;
    logic         pcsrce;
    logic [W-1:0] pctargete;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic [W-1:0] rd;
    logic [W-1:0] pcf;
    logic [W-1:0] pcplus4f;
    logic         fvalid;
    logic         fbusy;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Memory-model controls driven by the stimulus.
    logic         gnt_en;
    int unsigned  resp_delay;

    // Memory model state: one outstanding response with a countdown.
    logic         pend_valid;
    logic [W-1:0] pend_addr;
    int unsigned  pend_cnt;

    fetch_unit #(.WIDTH(W), .RESET_PC(RST_PC)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .STALLF     (stallf),
        .PCSRCE     (pcsrce),
        .PCTARGETE  (pctargete),
        .IMEM_REQ   (imem_req),
        .IMEM_ADDR  (imem_addr),
        .IMEM_GNT   (imem_gnt),
        .IMEM_RVALID(imem_rvalid),
        .IMEM_RDATA (imem_rdata),
        .RD         (rd),
        .PCF        (pcf),
        .PCPLUS4F   (pcplus4f),
        .FVALID     (fvalid),
        .FBUSY      (fbusy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    // Image: word at address a is ~a.
    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend_valid && (pend_cnt == 0);
    assign imem_rdata  = imem_rvalid ? ~pend_addr : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_cnt   <= 0;
        end else begin
            if (imem_rvalid) pend_valid <= 1'b0;
            if (imem_req && imem_gnt) begin
                pend_valid <= 1'b1;
                pend_addr  <= imem_addr;
                pend_cnt   <= resp_delay;
            end else if (pend_valid && pend_cnt != 0) begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_valid(input string tag, input logic [W-1:0] pc);
        check({tag, "_fvalid"}, {31'd0, fvalid}, 32'd1);
        check({tag, "_pcf"}, pcf, pc);
        check({tag, "_rd"}, rd, ~pc);
        check({tag, "_pcp4"}, pcplus4f, pc + 32'd4);
    endtask

    task automatic chk_req(input string tag, input logic [W-1:0] addr);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_fvalid"}, {31'd0, fvalid}, 32'd0);
        check({tag, "_fbusy"}, {31'd0, fbusy}, 32'd1);
        check({tag, "_rd"}, rd, 32'd0);
        check({tag, "_pcf"}, pcf, RST_PC);
        check({tag, "_pcp4"}, pcplus4f, RST_PC + 32'd4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        stallf     = 1'b0;
        pcsrce     = 1'b0;
        pctargete  = '0;
        gnt_en     = 1'b1;
        resp_delay = 0;

        // Reset state.
        step();
        step();
        chk_reset("rst");

        // 1: sequential fetch from RESET_PC, one instruction per two cycles.
        rst_n = 1'b1;
        #1;
        chk_req("t1_req0", 32'h100);
        step();
        check("t1_wait_req", {31'd0, imem_req}, 32'd0);
        check("t1_wait_fv", {31'd0, fvalid}, 32'd0);
        step();
        chk_valid("t1_v0", 32'h100);
        chk_req("t1_req1", 32'h104);
        step();
        check("t1_wait2_fv", {31'd0, fvalid}, 32'd0);
        check("t1_wait2_pcf", pcf, 32'h104);
        step();
        chk_valid("t1_v1", 32'h104);

        // 2: stall for three cycles at 0x104.
        stallf = 1'b1;
        #1;
        check("t2_stall_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_valid("t2_hold", 32'h104);
            check("t2_hold_req", {31'd0, imem_req}, 32'd0);
        end
        stallf = 1'b0;
        #1;
        chk_req("t2_release", 32'h108);
        step();
        step();
        chk_valid("t2_v2", 32'h108);

        // 4: redirect and stall together in VALID; redirect wins.
        pcsrce    = 1'b1;
        stallf    = 1'b1;
        pctargete = 32'h300;
        #1;
        check("t4_req_off", {31'd0, imem_req}, 32'd0);
        step();
        pcsrce = 1'b0;
        stallf = 1'b0;
        #1;
        chk_req("t4_target", 32'h300);
        check("t4_fv", {31'd0, fvalid}, 32'd0);
        step();
        step();
        chk_valid("t4_v", 32'h300);

        // 3: redirect in WAIT with a late response; the stale word is dropped.
        resp_delay = 2;
        step();                         // request 0x304 granted -> WAIT
        check("t3_wait_state", {30'd0, dbg_state}, 32'd1);
        pcsrce    = 1'b1;
        pctargete = 32'h200;
        step();                         // -> DRAIN, PC=0x200
        pcsrce = 1'b0;
        #1;
        check("t3_drain_state", {30'd0, dbg_state}, 32'd3);
        check("t3_drain_req", {31'd0, imem_req}, 32'd0);
        check("t3_drain_pcf", pcf, 32'h200);
        step();
        check("t3_drain2_fv", {31'd0, fvalid}, 32'd0);
        check("t3_stale_rv", {31'd0, imem_rvalid}, 32'd1);
        resp_delay = 0;
        step();                         // stale response absorbed -> REQ
        check("t3_after_fv", {31'd0, fvalid}, 32'd0);
        chk_req("t3_req", 32'h200);
        step();
        check("t3_wait_fv", {31'd0, fvalid}, 32'd0);
        step();
        chk_valid("t3_v", 32'h200);

        // 5: grant withheld for four cycles, then a redirect while still waiting.
        gnt_en = 1'b0;
        #1;
        chk_req("t5_adv", 32'h204);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_req("t5_hold", 32'h204);
            check("t5_hold_fv", {31'd0, fvalid}, 32'd0);
        end
        pcsrce    = 1'b1;
        pctargete = 32'h400;
        step();
        pcsrce = 1'b0;
        #1;
        chk_req("t5_switch", 32'h400);
        gnt_en = 1'b1;
        step();
        step();
        chk_valid("t5_v", 32'h400);

        // 6: address wrap, then reset asserted while in WAIT.
        pcsrce    = 1'b1;
        pctargete = 32'hFFFF_FFFC;
        step();
        pcsrce = 1'b0;
        #1;
        chk_req("t6_top", 32'hFFFF_FFFC);
        step();
        step();
        chk_valid("t6_v", 32'hFFFF_FFFC);
        check("t6_wrap_p4", pcplus4f, 32'h0);
        chk_req("t6_wrap", 32'h0);
        step();
        check("t6_wait_state", {30'd0, dbg_state}, 32'd1);
        check("t6_wait_pcf", pcf, 32'h0);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst");
        step();
        chk_reset("t6_rst_hold");
        rst_n = 1'b1;
        #1;
        chk_req("t6_restart", 32'h100);
        step();
        step();
        chk_valid("t6_v_restart", 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
